// File: rtl/mem_interface_if.sv
// Bundled bus-side and memory-side signals of the MAR/MDR memory stage.
// The master modport is the stage itself; the slave modport is its surroundings.
interface mem_interface_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] bus_in;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  mari;
    logic                  mdri;
    logic                  mdro;
    logic                  read;
    logic                  write;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        input  bus_in, mari, mdri, mdro, read, write, mem_rdata, mem_ready,
        output bus_out, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output bus_in, mari, mdri, mdro, read, write, mem_rdata, mem_ready,
        input  bus_out, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_interface.sv
// MAR/MDR memory stage: latches address/data from the internal bus and runs
// handshaked RAM reads/writes with a timeout, reporting busy/done/err.
module mem_interface #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input logic              clock,
    input logic              reset,
    mem_interface_if.master  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [CW-1:0]         counter;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr;
    logic                  done_q;
    logic                  err_q;

    // Counter holds the number of cycles already spent waiting; the access
    // aborts on the TIMEOUT-th cycle without mem_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            mar     <= '0;
            mdr     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (bus.mari)
                        mar <= bus.bus_in[ADDR_WIDTH-1:0];
                    if (bus.mdri)
                        mdr <= bus.bus_in;
                    if (bus.read && bus.write)
                        err_q <= 1'b1;
                    else if (bus.read)
                        state <= RD;
                    else if (bus.write)
                        state <= WR;
                end
                RD: begin
                    if (bus.mem_ready) begin
                        mdr    <= bus.mem_rdata;
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else if (counter == LAST) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                WR: begin
                    if (bus.mem_ready) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else if (counter == LAST) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_out   = bus.mdro ? mdr : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = mar;
    assign bus.mem_wdata = mdr;
    assign bus.mem_rd    = (state == RD);
    assign bus.mem_wr    = (state == WR);
endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: a small RAM model answers the
// handshake, and expected completions are queued and popped as they occur.
module tb_mem_interface;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] ram [0:511];

    mem_interface_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus();

    mem_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // RAM model: raise mem_ready after ready_delay busy cycles (never if <0)
    // and report which completion (1=done, 2=err, 0=none) came and when.
    task automatic run_mem(input int ready_delay, input int max_cycles,
                           output int kind, output int cycles);
        kind   = 0;
        cycles = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (ready_delay >= 0 && i >= ready_delay && (bus.mem_rd || bus.mem_wr)) begin
                bus.mem_ready = 1'b1;
                if (bus.mem_rd)
                    bus.mem_rdata = ram[bus.mem_addr];
                else
                    ram[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_ready = 1'b0;
            end
            step();
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'h0;
            cycles = i + 1;
            if (bus.done) begin kind = 1; break; end
            if (bus.err)  begin kind = 2; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", bus.err); end
        checks++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdwr: got %0b%0b expected 00", bus.mem_rd, bus.mem_wr); end
        checks++; if (bus.mem_addr !== 9'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.bus_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus_out: got %h expected 0", bus.bus_out); end
    endtask

    task automatic test_read();
        int kind;
        int cyc;
        ram[9'h105] = 32'hDEADBEEF;
        bus.bus_in = 32'h0000_0105;
        bus.mari   = 1'b1;
        step();
        bus.mari = 1'b0;
        bus.read = 1'b1;
        step();
        bus.read = 1'b0;
        checks++; if (bus.mem_addr !== 9'h105) begin errors++; $display("[TB] FAIL read_addr: got %h expected 105", bus.mem_addr); end
        checks++; if (bus.mem_rd !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL read_rd_busy: got %0b%0b expected 11", bus.mem_rd, bus.busy); end
        sb.push_back('{kind: 1, data: 32'hDEADBEEF, cycles: 1});
        run_mem(0, 40, kind, cyc);
        e = sb.pop_front();
        checks++; if (kind !== e.kind || cyc !== e.cycles) begin errors++; $display("[TB] FAIL read_done: got kind %0d after %0d expected kind %0d after %0d", kind, cyc, e.kind, e.cycles); end
        checks++; if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL read_idle: got busy %0b rd %0b expected 0 0", bus.busy, bus.mem_rd); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL read_done_width: got %0b expected 0", bus.done); end
        bus.mdro = 1'b1;
        #1;
        checks++; if (bus.bus_out !== e.data) begin errors++; $display("[TB] FAIL read_bus_out: got %h expected %h", bus.bus_out, e.data); end
        bus.mdro = 1'b0;
        #1;
        checks++; if (bus.bus_out !== 32'h0) begin errors++; $display("[TB] FAIL read_mdro_off: got %h expected 0", bus.bus_out); end
    endtask

    task automatic test_write_same_edge();
        int kind;
        int cyc;
        ram[9'h033] = 32'h0;
        bus.bus_in = 32'h0000_0033;
        bus.mari   = 1'b1;
        bus.mdri   = 1'b1;
        bus.write  = 1'b1;
        step();
        bus.mari  = 1'b0;
        bus.mdri  = 1'b0;
        bus.write = 1'b0;
        checks++; if (bus.mem_addr !== 9'h033) begin errors++; $display("[TB] FAIL write_addr: got %h expected 033", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h33) begin errors++; $display("[TB] FAIL write_wdata: got %h expected 33", bus.mem_wdata); end
        checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL write_wr: got wr %0b rd %0b expected 1 0", bus.mem_wr, bus.mem_rd); end
        sb.push_back('{kind: 1, data: 32'h33, cycles: 4});
        run_mem(3, 40, kind, cyc);
        e = sb.pop_front();
        checks++; if (kind !== e.kind || cyc !== e.cycles) begin errors++; $display("[TB] FAIL write_done: got kind %0d after %0d expected kind %0d after %0d", kind, cyc, e.kind, e.cycles); end
        checks++; if (ram[9'h033] !== e.data) begin errors++; $display("[TB] FAIL write_ram: got %h expected %h", ram[9'h033], e.data); end
        step();
    endtask

    task automatic test_timeout();
        int kind;
        int cyc;
        bus.bus_in = 32'h0000_0044;
        bus.mari   = 1'b1;
        bus.read   = 1'b1;
        step();
        bus.mari = 1'b0;
        bus.read = 1'b0;
        sb.push_back('{kind: 2, data: 32'h33, cycles: 15});
        run_mem(-1, 40, kind, cyc);
        e = sb.pop_front();
        checks++; if (kind !== e.kind || cyc !== e.cycles) begin errors++; $display("[TB] FAIL timeout_err: got kind %0d after %0d expected kind %0d after %0d", kind, cyc, e.kind, e.cycles); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle: got busy %0b done %0b expected 0 0", bus.busy, bus.done); end
        bus.mdro = 1'b1;
        #1;
        checks++; if (bus.bus_out !== e.data) begin errors++; $display("[TB] FAIL timeout_mdr: got %h expected %h", bus.bus_out, e.data); end
        bus.mdro = 1'b0;
        step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_width: got %0b expected 0", bus.err); end
    endtask

    task automatic test_illegal();
        int kind;
        int cyc;
        bus.bus_in = 32'h0000_0077;
        bus.mari   = 1'b1;
        bus.read   = 1'b1;
        bus.write  = 1'b1;
        step();
        bus.mari  = 1'b0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err: got err %0b busy %0b expected 1 0", bus.err, bus.busy); end
        checks++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL illegal_rdwr: got %0b%0b expected 00", bus.mem_rd, bus.mem_wr); end
        checks++; if (bus.mem_addr !== 9'h077) begin errors++; $display("[TB] FAIL illegal_mar_load: got %h expected 077", bus.mem_addr); end
        step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_width: got %0b expected 0", bus.err); end
        ram[9'h0AB] = 32'hCAFEF00D;
        bus.bus_in = 32'h0000_00AB;
        bus.mari   = 1'b1;
        bus.read   = 1'b1;
        step();
        bus.read   = 1'b0;
        bus.bus_in = 32'h0000_01FF;
        bus.mdri   = 1'b1;
        step();
        bus.mari = 1'b0;
        bus.mdri = 1'b0;
        checks++; if (bus.mem_addr !== 9'h0AB) begin errors++; $display("[TB] FAIL busy_mar_frozen: got %h expected 0ab", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h33) begin errors++; $display("[TB] FAIL busy_mdr_frozen: got %h expected 33", bus.mem_wdata); end
        sb.push_back('{kind: 1, data: 32'hCAFEF00D, cycles: 1});
        run_mem(0, 40, kind, cyc);
        e = sb.pop_front();
        bus.mdro = 1'b1;
        #1;
        checks++; if (kind !== e.kind || bus.bus_out !== e.data) begin errors++; $display("[TB] FAIL busy_read_data: got kind %0d data %h expected kind %0d data %h", kind, bus.bus_out, e.kind, e.data); end
        bus.mdro = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int          kind;
        int          cyc;
        logic [8:0]  addr;
        logic [31:0] data;
        for (int k = 0; k < 4; k++) begin
            addr = 9'($urandom_range(0, 511));
            data = $urandom;
            bus.bus_in = {23'h0, addr};
            bus.mari   = 1'b1;
            step();
            bus.mari   = 1'b0;
            bus.bus_in = data;
            bus.mdri   = 1'b1;
            bus.write  = 1'b1;
            step();
            bus.mdri  = 1'b0;
            bus.write = 1'b0;
            sb.push_back('{kind: 1, data: data, cycles: k + 1});
            run_mem(k, 40, kind, cyc);
            e = sb.pop_front();
            checks++; if (kind !== e.kind || cyc !== e.cycles || ram[addr] !== e.data) begin errors++; $display("[TB] FAIL b2b_write%0d: got kind %0d cyc %0d ram %h expected kind %0d cyc %0d ram %h", k, kind, cyc, ram[addr], e.kind, e.cycles, e.data); end
            bus.bus_in = 32'h0;
            bus.mdri   = 1'b1;
            bus.read   = 1'b1;
            step();
            bus.mdri = 1'b0;
            bus.read = 1'b0;
            sb.push_back('{kind: 1, data: data, cycles: 2});
            run_mem(1, 40, kind, cyc);
            e = sb.pop_front();
            bus.mdro = 1'b1;
            #1;
            checks++; if (kind !== e.kind || cyc !== e.cycles || bus.bus_out !== e.data) begin errors++; $display("[TB] FAIL b2b_read%0d: got kind %0d cyc %0d data %h expected kind %0d cyc %0d data %h", k, kind, cyc, bus.bus_out, e.kind, e.cycles, e.data); end
            bus.mdro = 1'b0;
        end
        step();
    endtask

    task automatic test_reset_mid_rd();
        int seen_done;
        bus.bus_in = 32'h0000_0010;
        bus.mari   = 1'b1;
        bus.read   = 1'b1;
        step();
        bus.mari = 1'b0;
        bus.read = 1'b0;
        step();
        checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("[TB] FAIL midrd_in_rd: got %0b expected 1", bus.mem_rd); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL midrd_abort: got busy %0b rd %0b expected 0 0", bus.busy, bus.mem_rd); end
        checks++; if (bus.mem_addr !== 9'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL midrd_regs: got mar %h mdr %h expected 000 0", bus.mem_addr, bus.mem_wdata); end
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            step();
            if (bus.done || bus.err) seen_done++;
        end
        bus.mem_ready = 1'b0;
        checks++; if (seen_done !== 0) begin errors++; $display("[TB] FAIL midrd_no_done: got %0d pulses expected 0", seen_done); end
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b1;
        errors        = 0;
        checks        = 0;
        bus.bus_in    = 32'h0;
        bus.mari      = 1'b0;
        bus.mdri      = 1'b0;
        bus.mdro      = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        $display("[TB] starting mem_interface bench");
        test_reset();
        test_read();
        test_write_same_edge();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_rd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
